// File: rtl/pixel_stream_sched_pkg.sv
// pixel_stream_sched_pkg: shared state encoding, pixel width and counter sizing helpers
package pixel_stream_sched_pkg;
   localparam int PIX_W = 8;
   typedef enum logic [1:0] {IDLE, STREAM, DRAIN, GAP} state_t;
   function automatic int cnt_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction
   function automatic int frame_pix(input int w, input int h);
      return w * h;
   endfunction
endpackage

// File: rtl/pixel_stream_sched_if.sv
// pixel_stream_sched_if: producer request/capture pins and the outgoing pixel stream
interface pixel_stream_sched_if;
   import pixel_stream_sched_pkg::*;
   logic             prod_ready;
   logic [PIX_W-1:0] prod_pixel;
   logic             prod_valid;
   logic [PIX_W-1:0] m_pixel;
   logic             m_valid;
   logic             m_ready;
   logic             m_sof;
   logic             m_eol;
   logic             m_eof;
   modport master (output prod_ready, m_pixel, m_valid, m_sof, m_eol, m_eof,
                   input prod_pixel, prod_valid, m_ready);
   modport slave (input prod_ready, m_pixel, m_valid, m_sof, m_eol, m_eof,
                  output prod_pixel, prod_valid, m_ready);
endinterface

// File: rtl/pixel_stream_sched_fifo.sv
// pixel_stream_sched_fifo: first-word-fall-through capture FIFO, push and pop allowed together when full
module pixel_stream_sched_fifo
   import pixel_stream_sched_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic             sensor_clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [PIX_W-1:0] din,
   output logic [PIX_W-1:0] dout,
   output logic [AW:0]      count,
   output logic             full,
   output logic             empty
);
   logic [PIX_W-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic wr_en, rd_en;
   assign full = count == (AW+1)'(DEPTH);
   assign empty = count == '0;
   assign rd_en = pop && !empty;
   assign wr_en = push && (!full || rd_en);
   assign dout = mem[rd_ptr];
   // pointer and occupancy tracking; pointers wrap naturally since DEPTH is a power of two
   always_ff @(posedge sensor_clk or negedge rst_n)
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count <= '0;
      end else begin
         wr_ptr <= wr_ptr + AW'(wr_en);
         rd_ptr <= rd_ptr + AW'(rd_en);
         count <= count + (AW+1)'(wr_en) - (AW+1)'(rd_en);
      end
   // storage array, contents need no reset because count gates visibility
   always_ff @(posedge sensor_clk)
      if (wr_en) mem[wr_ptr] <= din;
endmodule

// File: rtl/pixel_stream_sched.sv
// pixel_stream_sched: frame sequencer issuing producer requests and re-streaming pixels with sof/eol/eof (checkers under PIXEL_SCHED_CHK_EN)
module pixel_stream_sched
   import pixel_stream_sched_pkg::*;
#(
   parameter int IMG_WIDTH  = 32,
   parameter int IMG_HEIGHT = 32,
   parameter int FIFO_DEPTH = 4,
   parameter int FRAME_GAP  = 8
) (
   input  logic                     sensor_clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic                     continuous,
   input  logic                     stop,
   pixel_stream_sched_if.master     bus,
   output logic                     busy,
   output logic [15:0]              frame_cnt,
   output logic                     err
);
   localparam int FRAME_PIX = frame_pix(IMG_WIDTH, IMG_HEIGHT);
   localparam int RW = cnt_w(FRAME_PIX + 1);
   localparam int XW = cnt_w(IMG_WIDTH);
   localparam int YW = cnt_w(IMG_HEIGHT);
   localparam int GW = cnt_w(FRAME_GAP + 1);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   state_t state;
   logic [RW-1:0] req_cnt;
   logic [XW-1:0] x;
   logic [YW-1:0] y;
   logic [GW-1:0] gap_cnt;
   logic [CW-1:0] fifo_count;
   logic [CW:0] outstanding;
   logic [PIX_W-1:0] fifo_dout;
   logic prod_ready_q, cont_q, stop_pend, fifo_full, fifo_empty;
   logic pop, last_x, last_y, eof_pop, gap_done, enter, req;
   pixel_stream_sched_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .sensor_clk (sensor_clk),
      .rst_n      (rst_n),
      .push       (prod_ready_q),
      .pop        (pop),
      .din        (bus.prod_pixel),
      .dout       (fifo_dout),
      .count      (fifo_count),
      .full       (fifo_full),
      .empty      (fifo_empty)
   );
   assign last_x = x == XW'(IMG_WIDTH - 1);
   assign last_y = y == YW'(IMG_HEIGHT - 1);
   assign bus.m_valid = !fifo_empty;
   assign bus.m_pixel = bus.m_valid ? fifo_dout : '0;
   assign bus.m_sof = bus.m_valid && x == '0 && y == '0;
   assign bus.m_eol = bus.m_valid && last_x;
   assign bus.m_eof = bus.m_eol && last_y;
   assign pop = bus.m_valid && bus.m_ready;
   assign eof_pop = pop && last_x && last_y;
   assign gap_done = gap_cnt >= GW'(FRAME_GAP);
   assign enter = (state == IDLE && start) || (state == GAP && gap_done && cont_q && !stop_pend);
   // credit counts stored pixels plus both requests still travelling through the producer
   assign outstanding = {1'b0, fifo_count} + (CW+1)'(bus.prod_ready) + (CW+1)'(prod_ready_q);
   assign req = (enter || (state == STREAM && req_cnt < RW'(FRAME_PIX))) && outstanding < (CW+1)'(FIFO_DEPTH);
   // frame FSM with request issue, output position and frame bookkeeping
   always_ff @(posedge sensor_clk or negedge rst_n)
      if (!rst_n) begin
         state <= IDLE;
         bus.prod_ready <= 1'b0;
         prod_ready_q <= 1'b0;
         req_cnt <= '0;
         x <= '0;
         y <= '0;
         gap_cnt <= '0;
         cont_q <= 1'b0;
         stop_pend <= 1'b0;
         busy <= 1'b0;
         frame_cnt <= '0;
      end else begin
         bus.prod_ready <= req;
         prod_ready_q <= bus.prod_ready;
         req_cnt <= (enter ? '0 : req_cnt) + RW'(req);
         if (pop) x <= last_x ? '0 : x + 1'b1;
         if (pop && last_x) y <= last_y ? '0 : y + 1'b1;
         if (eof_pop) begin
            frame_cnt <= frame_cnt + 1'b1;
            cont_q <= continuous;
         end
         if (stop && (state != IDLE || start)) stop_pend <= 1'b1;
         case (state)
            IDLE: if (start) begin
               state <= STREAM;
               busy <= 1'b1;
               cont_q <= continuous;
            end
            STREAM: if (req_cnt == RW'(FRAME_PIX)) state <= DRAIN;
            DRAIN: if (eof_pop) begin
               state <= GAP;
               gap_cnt <= GW'(1);
            end
            GAP: begin
               gap_cnt <= gap_cnt + 1'b1;
               if (gap_done) begin
                  state <= enter ? STREAM : IDLE;
                  busy <= enter;
                  if (!enter) stop_pend <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
`ifdef PIXEL_SCHED_CHK_EN
   logic chk;
   assign chk = (prod_ready_q && !bus.prod_valid) || (prod_ready_q && fifo_full && !pop) || (pop && fifo_empty);
   // sticky protocol error flag with a simulation alarm
   always_ff @(posedge sensor_clk or negedge rst_n)
      if (!rst_n) err <= 1'b0;
      else begin
         if (chk) err <= 1'b1;
         assert (!chk) else $error("pixel_stream_sched: protocol error");
      end
`else
   assign err = 1'b0;
`endif
endmodule

// File: tb/tb_pixel_stream_sched.sv
// tb_pixel_stream_sched: directed vector table plus hand sequences for latency, gap, reset and checker
module tb_pixel_stream_sched;
   import pixel_stream_sched_pkg::*;
   localparam int W = 32, H = 32, N = W * H, DEPTH = 4, GAPC = 8;
   typedef struct {bit cont; int stop_pop; int rdy; int frames;} vec_t;
   logic sensor_clk = 0, rst_n = 1, start = 0, continuous = 0, stop = 0, kill = 0;
   logic busy, err;
   logic [15:0] frame_cnt;
   int rdy_pct = 100;
   int total = 0, passed = 0;
   logic [7:0] img [N];
   int p_idx;
   pixel_stream_sched_if bus();
   pixel_stream_sched #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .FIFO_DEPTH(DEPTH), .FRAME_GAP(GAPC)) dut (
      .sensor_clk (sensor_clk),
      .rst_n      (rst_n),
      .start      (start),
      .continuous (continuous),
      .stop       (stop),
      .bus        (bus),
      .busy       (busy),
      .frame_cnt  (frame_cnt),
      .err        (err)
   );
   always #5 sensor_clk = ~sensor_clk;
   assign bus.prod_valid = !kill;
   // producer model: one pixel per request, delivered the next cycle, index reset with rst_n
   always @(posedge sensor_clk or negedge rst_n)
      if (!rst_n) begin
         p_idx <= 0;
         bus.prod_pixel <= '0;
      end else if (bus.prod_ready) begin
         bus.prod_pixel <= img[p_idx];
         p_idx <= (p_idx == N - 1) ? 0 : p_idx + 1;
      end
   initial begin
      bus.m_ready = 1'b1;
      forever begin
         @(posedge sensor_clk);
         #1 bus.m_ready = ($urandom_range(99) < rdy_pct);
      end
   end
   // stream monitor: order, markers, stall stability, outstanding requests
   int pops, reqs, max_out, mon_bad = 0, exp_idx;
   bit stall_prev, got_first;
   logic [7:0] prev_pix, first_pix;
   logic [2:0] prev_mk;
   logic first_sof;
   always @(negedge sensor_clk)
      if (!rst_n) begin
         pops = 0; reqs = 0; max_out = 0; exp_idx = 0; stall_prev = 0; got_first = 0;
      end else begin
         if (stall_prev && (!bus.m_valid || bus.m_pixel != prev_pix || {bus.m_sof, bus.m_eol, bus.m_eof} != prev_mk)) mon_bad++;
         if (bus.prod_ready) reqs++;
         if (bus.m_valid && bus.m_ready) begin
            if (bus.m_pixel != img[exp_idx] || bus.m_sof != (exp_idx == 0) ||
                bus.m_eol != (exp_idx % W == W - 1) || bus.m_eof != (exp_idx == N - 1)) mon_bad++;
            if (!got_first) begin
               got_first = 1; first_pix = bus.m_pixel; first_sof = bus.m_sof;
            end
            exp_idx = (exp_idx + 1) % N;
            pops++;
         end
         if (reqs - pops > max_out) max_out = reqs - pops;
         stall_prev = bus.m_valid && !bus.m_ready;
         prev_pix = bus.m_pixel;
         prev_mk = {bus.m_sof, bus.m_eol, bus.m_eof};
      end
   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d, want %0d", name, act, exp);
   endtask
   task automatic do_reset();
      #1 rst_n = 0; kill = 0; start = 0; stop = 0;
      repeat (2) @(posedge sensor_clk);
      #1 rst_n = 1;
   endtask
   task automatic kick(input bit cont, input bit with_stop);
      @(posedge sensor_clk);
      #1 continuous = cont; start = 1; stop = with_stop;
      @(posedge sensor_clk);
      #1 start = 0; stop = 0;
   endtask
   task automatic wait_idle(input string name);
      bit done = 0;
      for (int c = 0; c < 20000 && !done; c++) begin
         @(posedge sensor_clk);
         #1 done = !busy;
      end
      chk(name, done, 1);
   endtask
   task automatic run_vec(input vec_t v, input int k);
      int bad0;
      bit done = 0, stopped;
      do_reset();
      bad0 = mon_bad;
      rdy_pct = v.rdy;
      stopped = v.stop_pop == 0;
      kick(v.cont, stopped);
      for (int c = 0; c < 20000 && !done; c++) begin
         @(posedge sensor_clk);
         #1 stop = v.stop_pop > 0 && !stopped && pops >= v.stop_pop;
         if (stop) stopped = 1;
         done = !busy;
      end
      stop = 0;
      rdy_pct = 100;
      chk($sformatf("v%0d_idle", k), done, 1);
      chk($sformatf("v%0d_frame_cnt", k), frame_cnt, v.frames);
      chk($sformatf("v%0d_pops", k), pops, v.frames * N);
      chk($sformatf("v%0d_stream_errs", k), mon_bad - bad0, 0);
      chk($sformatf("v%0d_outstanding_ok", k), max_out <= DEPTH, 1);
      chk($sformatf("v%0d_err", k), err, 0);
   endtask
   initial begin
      vec_t vecs[5];
      int bad0, t_r, t_v, e, r;
      for (int i = 0; i < N; i++) img[i] = 8'((i * 37 + (i >> 5) + 5) & 255);
      vecs[0] = '{cont: 1'b0, stop_pop: -1,      rdy: 100, frames: 1};
      vecs[1] = '{cont: 1'b0, stop_pop: -1,      rdy: 50,  frames: 1};
      vecs[2] = '{cont: 1'b1, stop_pop: N + 500, rdy: 100, frames: 2};
      vecs[3] = '{cont: 1'b1, stop_pop: 500,     rdy: 75,  frames: 1};
      vecs[4] = '{cont: 1'b1, stop_pop: 0,       rdy: 100, frames: 1};
      #2 rst_n = 0;
      repeat (2) @(negedge sensor_clk);
      chk("rst_prod_ready", bus.prod_ready, 0);
      chk("rst_m_valid", bus.m_valid, 0);
      chk("rst_m_pixel", bus.m_pixel, 0);
      chk("rst_markers", {bus.m_sof, bus.m_eol, bus.m_eof}, 0);
      chk("rst_busy", busy, 0);
      chk("rst_frame_cnt", frame_cnt, 0);
      chk("rst_err", err, 0);
      for (int k = 0; k < 5; k++) run_vec(vecs[k], k);
      // first-pixel latency: m_valid two cycles after the first prod_ready
      do_reset();
      kick(1'b0, 1'b0);
      t_r = -1; t_v = -1;
      for (int c = 0; c < 50 && t_v < 0; c++) begin
         @(negedge sensor_clk);
         if (bus.prod_ready && t_r < 0) t_r = c;
         if (bus.m_valid && t_v < 0) t_v = c;
      end
      chk("latency", t_v - t_r, 2);
      wait_idle("lat_idle");
      chk("lat_frame_cnt", frame_cnt, 1);
      // inter-frame gap in continuous mode
      do_reset();
      bad0 = mon_bad;
      kick(1'b1, 1'b0);
      e = -1; r = -1;
      for (int c = 0; c < 5000; c++) begin
         @(negedge sensor_clk);
         if (e < 0 && bus.m_valid && bus.m_ready && bus.m_eof) e = c;
         else if (e >= 0 && bus.prod_ready) begin
            r = c;
            break;
         end
      end
      chk("gap_cycles", r - e - 1, GAPC);
      for (int c = 0; c < 100 && pops <= N; c++) @(posedge sensor_clk);
      chk("gap_f2_first_pix", pops > N && mon_bad == bad0, 1);
      #1 stop = 1;
      @(posedge sensor_clk);
      #1 stop = 0;
      wait_idle("gap_idle");
      chk("gap_frame_cnt", frame_cnt, 2);
      chk("gap_stream_errs", mon_bad - bad0, 0);
      // asynchronous reset mid-frame, then a clean restart
      do_reset();
      kick(1'b0, 1'b0);
      for (int c = 0; c < 2000 && pops < 300; c++) @(posedge sensor_clk);
      #1 rst_n = 0;
      @(negedge sensor_clk);
      chk("mid_rst_prod_ready", bus.prod_ready, 0);
      chk("mid_rst_m_valid", bus.m_valid, 0);
      chk("mid_rst_m_pixel", bus.m_pixel, 0);
      chk("mid_rst_sof", bus.m_sof, 0);
      chk("mid_rst_busy", busy, 0);
      @(posedge sensor_clk);
      #1 rst_n = 1;
      bad0 = mon_bad;
      kick(1'b0, 1'b0);
      wait_idle("restart_idle");
      chk("restart_first_pix", first_pix, img[0]);
      chk("restart_first_sof", first_sof, 1);
      chk("restart_stream_errs", mon_bad - bad0, 0);
      chk("restart_frame_cnt", frame_cnt, 1);
`ifdef PIXEL_SCHED_CHK_EN
      do_reset();
      kick(1'b0, 1'b0);
      for (int c = 0; c < 20 && !bus.prod_ready; c++) @(negedge sensor_clk);
      @(posedge sensor_clk);
      #1 kill = 1;
      @(posedge sensor_clk);
      #1 kill = 0;
      @(negedge sensor_clk);
      chk("chk_err_set", err, 1);
      repeat (5) @(negedge sensor_clk);
      chk("chk_err_sticky", err, 1);
      do_reset();
      @(negedge sensor_clk);
      chk("chk_err_cleared", err, 0);
`endif
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
